// File: rtl/control_puntaje.sv
// control_puntaje: HEROE score controller with tick/bonus arbitration, clear/hold and BCD display.
// Optional best-score register is built when RECORD_PUNTAJE_EN is defined; record reads 0 otherwise.
module control_puntaje #(
  parameter int unsigned DIVISOR    = 27000000,
  parameter int unsigned MAX_PUNTOS = 999,
  parameter int unsigned BONO_M1    = 10,
  parameter int unsigned BONO_M2    = 30,
  parameter int unsigned BONO_M3    = 45
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  presente,
  input  logic [1:0]  W_or_L,
  input  logic [1:0]  mundo,
  input  logic        bono_tomado,
  output logic [9:0]  puntos,
  output logic [27:0] display_puntaje,
  output logic        ocupado,
  output logic [9:0]  record
);

  localparam int unsigned CntW     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CntW-1:0] PrescMax = CntW'(DIVISOR - 1);
  localparam logic [10:0] MaxPts   = 11'(MAX_PUNTOS);
  localparam logic [6:0]  Glyph0   = 7'b1000000;

  localparam logic [2:0] PresOff  = 3'd0;
  localparam logic [2:0] PresWlcm = 3'd1;
  localparam logic [2:0] PresCh   = 3'd2;
  localparam logic [2:0] PresGame = 3'd3;
  localparam logic [2:0] PresWl   = 3'd4;
  localparam logic [2:0] PresPa   = 3'd5;

  typedef enum logic [2:0] {StIdle, StAddB, StAddT, StClr, StBcd, StOut} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] presc_q, presc_d;
  logic [2:0]      presente_q;
  logic            bono_q;
  logic            tick_pend_q, tick_pend_d;
  logic            bono_pend_q, bono_pend_d;
  logic [9:0]      puntos_q, puntos_d;
  logic [25:0]     dd_q, dd_d;   // {bcd[15:0], bin[9:0]} double-dabble shift register
  logic [3:0]      cnt_q, cnt_d;
  logic [27:0]     disp_q, disp_d;

  logic        habil, tick, bono_edge, clear, hold;
  logic [9:0]  bonus_val, pts_b, pts_t;
  logic [10:0] sum_b, sum_t;

  function automatic logic [25:0] dabble_step(input logic [25:0] v);
    logic [25:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[10+4*i +: 4] >= 4'd5) t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
    end
    return {t[24:0], 1'b0};
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  assign habil     = (presente == PresGame) && (W_or_L == 2'b00);
  assign tick      = (presc_q == PrescMax);
  assign bono_edge = bono_tomado & ~bono_q;
  assign clear     = (presente != presente_q) && ((presente == PresWlcm) || (presente == PresOff));
  assign hold      = (presente == PresCh) || (presente == PresPa) || (presente == PresWl);
  assign presc_d   = (clear || tick) ? '0 : presc_q + 1'b1;

  always_comb begin
    case (mundo)
      2'd1:    bonus_val = 10'(BONO_M1);
      2'd2:    bonus_val = 10'(BONO_M2);
      2'd3:    bonus_val = 10'(BONO_M3);
      default: bonus_val = 10'd0;
    endcase
  end

  assign sum_b = {1'b0, puntos_q} + {1'b0, bonus_val};
  assign sum_t = {1'b0, puntos_q} + 11'd1;
  assign pts_b = (sum_b > MaxPts) ? MaxPts[9:0] : sum_b[9:0];
  assign pts_t = (sum_t > MaxPts) ? MaxPts[9:0] : sum_t[9:0];

  always_comb begin
    state_d     = state_q;
    puntos_d    = puntos_q;
    dd_d        = dd_q;
    cnt_d       = cnt_q;
    disp_d      = disp_q;
    tick_pend_d = tick_pend_q | (tick & habil);
    bono_pend_d = bono_pend_q | (bono_edge & habil);
    // IDLE looks at the post-set flags so a fresh event starts its ADD on the next cycle.
    unique case (state_q)
      StIdle: begin
        if (bono_pend_d)      state_d = StAddB;
        else if (tick_pend_d) state_d = StAddT;
      end
      StAddB: begin
        bono_pend_d = 1'b0;
        if (!hold) puntos_d = pts_b;
        state_d = StBcd;
      end
      StAddT: begin
        tick_pend_d = tick & habil;
        if (!hold) puntos_d = pts_t;
        state_d = StBcd;
      end
      StClr: state_d = StBcd;
      StBcd: begin
        dd_d  = dabble_step(dd_q);
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = StOut;
      end
      StOut: begin
        disp_d  = {glyph(dd_q[25:22]), glyph(dd_q[21:18]), glyph(dd_q[17:14]), glyph(dd_q[13:10])};
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clear) begin
      puntos_d    = '0;
      tick_pend_d = 1'b0;
      bono_pend_d = 1'b0;
      state_d     = (state_q == StIdle) ? StClr : StBcd;
    end
    // Snapshot the freshly written score on every (re)entry into BCD.
    if ((state_d == StBcd) && ((state_q != StBcd) || clear)) begin
      dd_d  = {16'd0, puntos_d};
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      presente_q  <= PresOff;
      bono_q      <= 1'b0;
      tick_pend_q <= 1'b0;
      bono_pend_q <= 1'b0;
      puntos_q    <= '0;
      dd_q        <= '0;
      cnt_q       <= '0;
      disp_q      <= {4{Glyph0}};
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      presente_q  <= presente;
      bono_q      <= bono_tomado;
      tick_pend_q <= tick_pend_d;
      bono_pend_q <= bono_pend_d;
      puntos_q    <= puntos_d;
      dd_q        <= dd_d;
      cnt_q       <= cnt_d;
      disp_q      <= disp_d;
    end
  end

  assign puntos          = puntos_q;
  assign display_puntaje = disp_q;
  assign ocupado         = (state_q != StIdle);

`ifdef RECORD_PUNTAJE_EN
  logic [9:0] record_q, record_d;

  always_comb begin
    record_d = record_q;
    if ((presente == PresWl) && (presente_q != PresWl) && (puntos_q > record_q)) record_d = puntos_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) record_q <= '0;
    else     record_q <= record_d;
  end

  assign record = record_q;
`else
  assign record = '0;
`endif

endmodule
